// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - data-bus and interrupt signal bundle for irq_ctrl
interface irq_ctrl_if #(
  parameter int NIRQ = 6
);
  logic            cs;
  logic            we;
  logic [1:0]      addr;
  logic [31:0]     wd;
  logic [31:0]     rd;
  logic [NIRQ-1:0] dev_irq;
  logic [NIRQ-1:0] interrupt;
  logic            irq_any;

  modport master (
    output cs, we, addr, wd, dev_irq,
    input  rd, interrupt, irq_any
  );

  modport slave (
    input  cs, we, addr, wd, dev_irq,
    output rd, interrupt, irq_any
  );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt source controller driving the CP0 interrupt bus (macro IRQ_SYNC_EN adds a 2-flop input synchronizer)
module irq_ctrl #(
  parameter int NIRQ = 6
) (
  input  logic      clk,
  input  logic      rst,
  irq_ctrl_if.slave bus
);

  // Encoding keeps the output bit equal to state bit 0, so each interrupt
  // line comes straight from a flop.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ASSERT = 2'b01,
    S_GAP    = 2'b10
  } state_t;

`ifdef IRQ_SYNC_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif

  logic [NIRQ-1:0]   lvl;
  logic [NIRQ-1:0]   lvl_d;
  logic [STAGES-1:0] primed;
  logic [NIRQ-1:0]   edge_ev;
  logic [NIRQ-1:0]   pend;
  logic [NIRQ-1:0]   ovf;
  logic [NIRQ-1:0]   mask;
  logic [NIRQ-1:0]   act;
  logic [NIRQ-1:0]   force_set;
  logic [NIRQ-1:0]   pend_clr;
  logic [NIRQ-1:0]   ovf_clr;
  logic [NIRQ-1:0]   event_set;
  logic [NIRQ-1:0]   irq_line;
  logic [2:0]        stat_idx;
  logic [31:0]       rdata;
  logic              irq_any_q;
  logic              wr_en;
  logic              unused_wd;
  state_t            state   [NIRQ];
  state_t            state_n [NIRQ];

  assign wr_en     = bus.cs & bus.we;
  assign unused_wd = ^{bus.wd[31:8+NIRQ], bus.wd[7:NIRQ]};

`ifdef IRQ_SYNC_EN
  logic [NIRQ-1:0] sync1;

  // Two-flop synchronizer followed by the edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      sync1 <= bus.dev_irq;
      lvl   <= sync1;
      lvl_d <= lvl;
    end
  end
`else
  // Single input register followed by the edge-detect flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      lvl   <= bus.dev_irq;
      lvl_d <= lvl;
    end
  end
`endif

  // Tracks pipeline fill after reset: the first staged sample only sets the
  // baseline level, so an input held high across reset is not an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) primed <= '0;
    else     primed <= {primed[STAGES-2:0], 1'b1};
  end

  assign edge_ev = primed[STAGES-1] ? (lvl & ~lvl_d) : '0;

  // Decode bus writes into set/clear vectors; edge and FORCE merge into one event
  always_comb begin
    force_set = '0;
    pend_clr  = '0;
    ovf_clr   = '0;
    if (wr_en && bus.addr == 2'd3) force_set = bus.wd[NIRQ-1:0];
    if (wr_en && bus.addr == 2'd0) begin
      pend_clr = bus.wd[NIRQ-1:0];
      ovf_clr  = bus.wd[8 +: NIRQ];
    end
    event_set = edge_ev | force_set;
  end

  // Pending/overflow/mask registers; a set beats a same-cycle W1C
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      ovf  <= '0;
      mask <= '0;
    end else begin
      pend <= (pend & ~pend_clr) | event_set;
      ovf  <= (ovf & ~ovf_clr) | (event_set & pend & ~pend_clr);
      if (wr_en && bus.addr == 2'd1) mask <= bus.wd[NIRQ-1:0];
    end
  end

  assign act = pend & mask;

  // Priority encoder, highest line index wins
  always_comb begin
    stat_idx = 3'd0;
    for (int i = 0; i < NIRQ; i++) begin
      if (act[i]) stat_idx = 3'(i);
    end
  end

  // Register read mux
  always_comb begin
    rdata = '0;
    if (bus.cs) begin
      case (bus.addr)
        2'd0: begin
          rdata[NIRQ-1:0] = pend;
          rdata[8 +: NIRQ] = ovf;
        end
        2'd1: rdata[NIRQ-1:0] = mask;
        2'd2: begin
          rdata[3]   = |act;
          rdata[2:0] = stat_idx;
        end
        default: rdata = '0;
      endcase
    end
  end

  // Per-line output state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NIRQ; i++) state[i] <= S_IDLE;
    end else begin
      for (int i = 0; i < NIRQ; i++) state[i] <= state_n[i];
    end
  end

  // Per-line next state: GAP forces a low cycle between assertions
  always_comb begin
    for (int i = 0; i < NIRQ; i++) begin
      state_n[i] = state[i];
      case (state[i])
        S_IDLE:   if (act[i])  state_n[i] = S_ASSERT;
        S_ASSERT: if (!act[i]) state_n[i] = S_GAP;
        S_GAP:    state_n[i] = S_IDLE;
        default:  state_n[i] = S_IDLE;
      endcase
    end
  end

  // Interrupt lines taken directly from state bit 0
  always_comb begin
    irq_line = '0;
    for (int i = 0; i < NIRQ; i++) irq_line[i] = state[i][0];
  end

  // irq_any trails the interrupt lines by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_any_q <= 1'b0;
    else     irq_any_q <= |irq_line;
  end

  assign bus.interrupt = irq_line;
  assign bus.irq_any   = irq_any_q;
  assign bus.rd        = rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - directed scoreboard bench for irq_ctrl
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb [$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cs   = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.wd   = d;
    tick();
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
    bus.wd   = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    d = bus.rd;
    bus.cs = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wd = '0; bus.dev_irq = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    expect_val("rst_interrupt", 32'h0);  check(32'(bus.interrupt));
    expect_val("rst_irq_any", 32'h0);    check(32'(bus.irq_any));
    expect_val("rst_pend", 32'h0);       rd_reg(2'd0, d); check(d);
    expect_val("rst_mask", 32'h0);       rd_reg(2'd1, d); check(d);
    expect_val("rst_stat", 32'h0);       rd_reg(2'd2, d); check(d);

    // Device edge on line 2 with all lines unmasked
    wr(2'd1, 32'h3F);
    expect_val("edge_to_pend_latency", 32'(LAT));
    bus.dev_irq = 6'b000100;
    tick();
    bus.dev_irq = '0;
    cnt = 1;
    rd_reg(2'd0, d);
    while (d[5:0] == 6'd0 && cnt < 10) begin
      tick();
      cnt++;
      rd_reg(2'd0, d);
    end
    check(32'(cnt));
    expect_val("pend_after_edge", 32'h04);      rd_reg(2'd0, d); check(d);
    expect_val("stat_line2", 32'hA);            rd_reg(2'd2, d); check(d);
    expect_val("rd_zero_without_cs", 32'h0);    bus.addr = 2'd0; #1; check(bus.rd);
    expect_val("int_not_yet", 32'h0);           check(32'(bus.interrupt));
    expect_val("int_line2", 32'h04);            tick(); check(32'(bus.interrupt));
    expect_val("irq_any_follows", 32'h1);       tick(); check(32'(bus.irq_any));

    // W1C drops the line after one cycle and holds it low
    wr(2'd0, 32'h04);
    expect_val("int_held_at_clear_edge", 32'h04); check(32'(bus.interrupt));
    expect_val("int_gap", 32'h0);               tick(); check(32'(bus.interrupt));
    expect_val("pend_cleared", 32'h0);          rd_reg(2'd0, d); check(d);
    expect_val("int_idle", 32'h0);              tick(); check(32'(bus.interrupt));

    // Software FORCE with mask changes
    wr(2'd1, 32'h0);
    wr(2'd3, 32'h21);
    expect_val("pend_forced", 32'h21);          rd_reg(2'd0, d); check(d);
    expect_val("int_masked", 32'h0);            tick(); check(32'(bus.interrupt));
    wr(2'd1, 32'h01);
    expect_val("int0_rise", 32'h01);            tick(); check(32'(bus.interrupt));
    expect_val("stat_line0", 32'h8);            rd_reg(2'd2, d); check(d);
    wr(2'd1, 32'h21);
    expect_val("stat_line5", 32'hD);            rd_reg(2'd2, d); check(d);
    wr(2'd0, 32'h21);
    tick(); tick();

    // Two events on line 1 without clearing set overflow
    bus.dev_irq = 6'b000010; tick(); bus.dev_irq = '0; repeat (3) tick();
    bus.dev_irq = 6'b000010; tick(); bus.dev_irq = '0; repeat (3) tick();
    expect_val("pend_ovf", 32'h202);            rd_reg(2'd0, d); check(d);
    wr(2'd0, 32'h202);
    expect_val("pend_ovf_cleared", 32'h0);      rd_reg(2'd0, d); check(d);

    // Event on line 3 arriving in the same cycle as its W1C
    wr(2'd1, 32'h08);
    wr(2'd3, 32'h08);
    expect_val("int3_forced", 32'h08);          tick(); check(32'(bus.interrupt));
    bus.dev_irq = 6'b001000;
    repeat (LAT - 1) tick();
    wr(2'd0, 32'h08);
    bus.dev_irq = '0;
    expect_val("set_beats_clear", 32'h08);      rd_reg(2'd0, d); check(d);
    expect_val("int3_stays_0", 32'h08);         tick(); check(32'(bus.interrupt));
    expect_val("int3_stays_1", 32'h08);         tick(); check(32'(bus.interrupt));

    // Clear first, then re-force: line passes through GAP and IDLE
    wr(2'd0, 32'h08);
    wr(2'd3, 32'h08);
    expect_val("int3_gap", 32'h0);              check(32'(bus.interrupt));
    expect_val("int3_idle", 32'h0);             tick(); check(32'(bus.interrupt));
    expect_val("int3_reassert", 32'h08);        tick(); check(32'(bus.interrupt));

    // Asynchronous reset while every line is asserted
    wr(2'd1, 32'h3F);
    wr(2'd3, 32'h3F);
    expect_val("int_all", 32'h3F);              tick(); check(32'(bus.interrupt));
    bus.dev_irq = 6'h3F;
    tick(); tick();
    #1 rst = 1'b1;
    #1;
    expect_val("arst_interrupt", 32'h0);        check(32'(bus.interrupt));
    expect_val("arst_irq_any", 32'h0);          check(32'(bus.irq_any));
    expect_val("arst_pend", 32'h0);             rd_reg(2'd0, d); check(d);
    expect_val("arst_mask", 32'h0);             rd_reg(2'd1, d); check(d);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) tick();
    expect_val("no_replay_held_high", 32'h0);   rd_reg(2'd0, d); check(d);
    bus.dev_irq = '0;
    repeat (3) tick();
    bus.dev_irq = 6'h01;
    repeat (LAT) tick();
    expect_val("fresh_edge_after_reset", 32'h01); rd_reg(2'd0, d); check(d);
    bus.dev_irq = '0;
    tick();

    if (sb.size() != 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
